dbg_mon_mem_ctrl: RTL
=====================

DBG_MON_MEM_CTRL -- requirements
Module: dbg_mon_mem_ctrl

Interface
REQ-001 Parameter ADDR_W, 8, word-address width of the on-chip debug RAM (256 x 32-bit).
REQ-002 Parameter TIMEOUT_CYCLES, 255, maximum wait cycles on mem_waitrequest before abort; used only with DBG_MON_TIMEOUT_EN.
REQ-003 clk  in  1  sole clock; all logic rising-edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 jdo  in  38  JTAG debug data, already synchronized into clk domain.
REQ-006 take_action_ocimem_a  in  1  one-cycle pulse: load address / optional read.
REQ-007 take_action_ocimem_b  in  1  one-cycle pulse: write data to current address.
REQ-008 take_no_action_ocimem_a  in  1  one-cycle pulse: streaming read at current address.
REQ-009 debugack  in  1  CPU halted in debug mode; accesses permitted only when 1.
REQ-010 mem_address  out  ADDR_W  word address.
REQ-011 mem_read / mem_write  out  1 each  access strobes, held until accepted.
REQ-012 mem_writedata  out  32  write data.
REQ-013 mem_waitrequest  in  1  slave stall; access accepted on cycle where strobe=1 and waitrequest=0.
REQ-014 mem_readdata  in  32  valid exactly one cycle after read acceptance.
REQ-015 MonDReg  out  32  monitor data register returned to the debug TCK logic.
REQ-016 monitor_ready  out  1  1 = idle, ready for a command.
REQ-017 monitor_error  out  1  sticky error flag.

Function
REQ-018 Decode: ocimem_a -> MonAReg <= jdo[ADDR_W+24:25] (ADDR_W bits from bit 25); read issued if jdo[35]=1; monitor_error cleared.
REQ-019 Decode: ocimem_b -> write of jdo[34:3] to MonAReg; MonDReg <= jdo[34:3].
REQ-020 Decode: no_action_ocimem_a -> read at MonAReg.
REQ-021 Simultaneous pulses: priority a > b > no_action_a; lower-priority pulses in same cycle discarded silently.
REQ-022 FSM states IDLE, REQ, RDCAP; IDLE->REQ on accepted command; REQ->IDLE on write acceptance; REQ->RDCAP on read acceptance; RDCAP->IDLE unconditionally, capturing mem_readdata into MonDReg.
REQ-023 Latency with waitrequest=0: write 1 cycle in REQ; read 2 cycles (REQ, RDCAP); monitor_ready returns 1 the cycle after.
REQ-024 monitor_ready = 1 only in IDLE.
REQ-025 Command pulse while not IDLE: dropped, monitor_error set (overrun); except ocimem_a, which still clears no error while busy and is itself dropped.
REQ-026 Command with debugack=0: no memory access, monitor_error set; ocimem_a address load still performed.
REQ-027 MonAReg increments by 1 after each accepted access, wrapping 2^ADDR_W-1 -> 0.
REQ-028 mem_read and mem_write never asserted together; mem_address/mem_writedata stable while strobe held.

Reset
REQ-029 Reset asserts asynchronously: state IDLE, MonAReg 0, MonDReg 0, mem_read 0, mem_write 0, mem_writedata 0, monitor_ready 1, monitor_error 0.
REQ-030 Reset mid-access aborts it immediately; no capture, no increment.

Configuration
REQ-031 Macro DBG_MON_TIMEOUT_EN defined: counter runs in REQ; at TIMEOUT_CYCLES consecutive waitrequest cycles strobe drops, monitor_error set, MonDReg <= 32'hDEADBEEF, FSM -> IDLE, address not incremented.
REQ-032 Macro absent: no counter, REQ waits indefinitely; monitor_error sources only REQ-025/REQ-026.

Structure
REQ-033 Shared package holds FSM state enum, jdo field bit positions, timeout fill constant 32'hDEADBEEF.
REQ-034 No sub-module; single flat block.

Verification
REQ-035 ocimem_a jdo[35]=1, address 0x10, readdata 0x12345678, waitrequest 0 -> MonDReg=0x12345678 after 2 cycles, MonAReg=0x11, ready=1.
REQ-036 ocimem_b data 0xCAFEF00D at MonAReg=0xFF with waitrequest high 3 cycles -> write held 4 cycles with stable data, MonAReg wraps to 0x00.
REQ-037 no_action_ocimem_a during REQ -> pulse dropped, monitor_error=1; next ocimem_a clears it.
REQ-038 ocimem_a and ocimem_b same cycle -> only address load/read executed, no write strobe.
REQ-039 debugack=0 with ocimem_b -> no mem_write, monitor_error=1; with DBG_MON_TIMEOUT_EN, waitrequest stuck 1 -> abort after 255 cycles, MonDReg=0xDEADBEEF, error=1.
REQ-040 reset pulsed during REQ -> mem_read low same cycle, all outputs at REQ-029 values.

Source files
------------

// File: rtl/dbg_mon_mem_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// dbg_mon_mem_ctrl_pkg
// Shared definitions for the debug monitor memory controller:
//   - FSM state encoding
//   - bit positions of the fields carried on the 38-bit jdo bus
//   - fill word returned in MonDReg when an access is aborted on timeout
// -----------------------------------------------------------------------------
package dbg_mon_mem_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_RDCAP = 2'd2
    } mon_state_t;

    localparam int JDO_W        = 38;
    localparam int JDO_RD_BIT   = 35;  // ocimem_a: issue a read after the address load
    localparam int JDO_ADDR_LSB = 25;  // ocimem_a: word address, ADDR_W bits wide
    localparam int JDO_DATA_MSB = 34;  // ocimem_b: write data
    localparam int JDO_DATA_LSB = 3;

    localparam logic [31:0] TIMEOUT_FILL = 32'hDEAD_BEEF;

endpackage

// File: rtl/dbg_mon_mem_ctrl.sv
// -----------------------------------------------------------------------------
// dbg_mon_mem_ctrl
// Debug monitor bridge between the JTAG debug command pulses and the on-chip
// debug RAM. One access at a time; a command is only accepted while idle.
//
// Ports
//   clk, reset                 clock, asynchronous active-high reset
//   jdo[37:0]                  debug data (address, read flag, write data)
//   take_action_ocimem_a       load address, optionally start a read
//   take_action_ocimem_b       write jdo data at the current address
//   take_no_action_ocimem_a    read at the current address
//   debugack                   CPU halted; accesses are refused when low
//   mem_address/read/write/writedata, mem_waitrequest, mem_readdata
//                              memory master port (strobes held until accepted)
//   MonDReg                    monitor data register
//   monitor_ready              1 while idle
//   monitor_error              sticky error (overrun, refused access, timeout)
//
// Build option
//   DBG_MON_TIMEOUT_EN         abort an access after TIMEOUT_CYCLES stalled
//                              cycles; without it a stalled access waits forever.
// -----------------------------------------------------------------------------
module dbg_mon_mem_ctrl
    import dbg_mon_mem_ctrl_pkg::*;
#(
    parameter int ADDR_W         = 8,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [JDO_W-1:0]  jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic              take_no_action_ocimem_a,
    input  logic              debugack,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_read,
    output logic              mem_write,
    output logic [31:0]       mem_writedata,
    input  logic              mem_waitrequest,
    input  logic [31:0]       mem_readdata,
    output logic [31:0]       MonDReg,
    output logic              monitor_ready,
    output logic              monitor_error
);

    // Elaboration-time sanity check on the timeout length.
    if (TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    mon_state_t        state_reg, state_next;
    logic [ADDR_W-1:0] mon_a_reg, mon_a_next;
    logic [31:0]       mon_d_reg, mon_d_next;
    logic [31:0]       wdata_reg, wdata_next;
    logic              err_reg, err_next;
    logic              is_wr_reg, is_wr_next;

    logic              any_cmd;
    logic [ADDR_W-1:0] jdo_addr;
    logic [31:0]       jdo_data;

    assign any_cmd  = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
    assign jdo_addr = jdo[JDO_ADDR_LSB +: ADDR_W];
    assign jdo_data = jdo[JDO_DATA_MSB:JDO_DATA_LSB];

    logic unused_jdo;
    assign unused_jdo = ^{jdo[JDO_W-1:JDO_RD_BIT+1], jdo[JDO_DATA_LSB-1:0]};

`ifdef DBG_MON_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             timeout_hit;

    // Fires on the TIMEOUT_CYCLES-th consecutive stalled cycle in REQ.
    assign timeout_hit = mem_waitrequest && (cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

    always_comb begin
        cnt_next = '0;
        if (state_reg == ST_REQ && mem_waitrequest && !timeout_hit) begin
            cnt_next = cnt_reg + 1'b1;
        end
    end
`else
    logic timeout_hit;
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            mon_a_reg <= '0;
            mon_d_reg <= '0;
            wdata_reg <= '0;
            err_reg   <= 1'b0;
            is_wr_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            mon_a_reg <= mon_a_next;
            mon_d_reg <= mon_d_next;
            wdata_reg <= wdata_next;
            err_reg   <= err_next;
            is_wr_reg <= is_wr_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        mon_a_next = mon_a_reg;
        mon_d_next = mon_d_reg;
        wdata_next = wdata_reg;
        err_next   = err_reg;
        is_wr_next = is_wr_reg;

        unique case (state_reg)
            ST_IDLE: begin
                // Only the highest-priority pulse is looked at.
                if (take_action_ocimem_a) begin
                    mon_a_next = jdo_addr;
                    err_next   = 1'b0;
                    // Any command arriving while the CPU is not halted is
                    // flagged, even a pure address load.
                    if (!debugack) begin
                        err_next = 1'b1;
                    end else if (jdo[JDO_RD_BIT]) begin
                        is_wr_next = 1'b0;
                        state_next = ST_REQ;
                    end
                end else if (take_action_ocimem_b) begin
                    mon_d_next = jdo_data;
                    if (!debugack) begin
                        err_next = 1'b1;
                    end else begin
                        wdata_next = jdo_data;
                        is_wr_next = 1'b1;
                        state_next = ST_REQ;
                    end
                end else if (take_no_action_ocimem_a) begin
                    if (!debugack) begin
                        err_next = 1'b1;
                    end else begin
                        is_wr_next = 1'b0;
                        state_next = ST_REQ;
                    end
                end
            end

            ST_REQ: begin
                // Busy: every command is an overrun, ocimem_a included.
                if (any_cmd) begin
                    err_next = 1'b1;
                end
                if (!mem_waitrequest) begin
                    mon_a_next = mon_a_reg + 1'b1;
                    state_next = is_wr_reg ? ST_IDLE : ST_RDCAP;
                end else if (timeout_hit) begin
                    err_next   = 1'b1;
                    mon_d_next = TIMEOUT_FILL;
                    state_next = ST_IDLE;
                end
            end

            ST_RDCAP: begin
                if (any_cmd) begin
                    err_next = 1'b1;
                end
                mon_d_next = mem_readdata;
                state_next = ST_IDLE;
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Strobes decode straight from registered state so a reset drops them
    // in the same cycle, and only one of them can ever be high.
    assign mem_read      = (state_reg == ST_REQ) && !is_wr_reg;
    assign mem_write     = (state_reg == ST_REQ) &&  is_wr_reg;
    assign mem_address   = mon_a_reg;
    assign mem_writedata = wdata_reg;
    assign MonDReg       = mon_d_reg;
    assign monitor_ready = (state_reg == ST_IDLE);
    assign monitor_error = err_reg;

endmodule
